paddle_pot_timer: RTL
=====================

Name: paddle_pot_timer

Overview:
- Emulates the four paddle potentiometer/capacitor charge circuits that feed the TIA dumped input ports (idump[3:0]).
- The TIA drives its dump-transistor state out on i_out. While dumping, the caps are held discharged. After release, each input reads 1 once a scanline count proportional to paddle position has elapsed.
- Sits directly upstream of the TIA instance in the Atari7800 top. It consumes i_out and tia_hsync from that top and produces idump.

Parameters:
- MIN_LINES, 2, fixed scanline offset added to every threshold (models minimum RC charge time).
- CNT_W, 9, width of each charge counter; counters saturate at 2^CNT_W-1.

Ports:
- clk_sys  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- dump  in  4  TIA dump state per channel (1 = capacitor grounded); driven from TIA i_out.
- hsync  in  1  TIA horizontal sync; the rising edge is one scanline tick.
- pot0  in  8  paddle 0 position (0 = fully left/fastest charge).
- pot1  in  8  paddle 1 position.
- pot2  in  8  paddle 2 position.
- pot3  in  8  paddle 3 position.
- pot_en  in  4  per-channel paddle present; 0 = unconnected input.
- idump  out  4  charge-complete level per channel, to TIA i[3:0].
- charging  out  4  per-channel status: released and not yet complete (debug/OSD).

Behaviour:
- Line tick:
  - hsync_d registers hsync.
  - line_tick = hsync & ~hsync_d, one clk_sys cycle wide.
  - A tick on the first cycle after reset is impossible (hsync_d resets to 1).
- Per channel n, state machine with three states: DUMP, CHARGE, DONE.
  - DUMP: cnt=0, idump[n]=0, charging[n]=0.
    - On the cycle dump[n] falls: latch thr[n] = pot_n + MIN_LINES as a CNT_W-bit sum (no overflow at pot=255 with default widths), then go to CHARGE.
  - CHARGE: charging[n]=1.
    - Each line_tick: cnt <= cnt+1, saturating at all-ones.
    - When cnt+1 >= thr[n] on a tick, go to DONE in that same tick. idump[n] rises on the clk_sys edge that registers the tick, i.e. 1 cycle after line_tick.
  - DONE: idump[n]=1, charging[n]=0. Holds until dump[n] rises.
  - Any state: dump[n]=1 forces DUMP on the next edge. dump takes priority over a simultaneous line_tick.
- Threshold latching: thr[n] is latched only at dump release. pot changes during CHARGE/DONE have no effect until the next dump cycle.
- pot_en[n]=0: idump[n] is forced to 1 whenever dump[n]=0 (floating input charges at once), and the state machine is held in DUMP.
  - pot_en rising mid-frame takes effect at the next dump release.
  - pot_en falling mid-charge abandons the charge: go to DUMP.
- Saturation: cnt never wraps. With saturation at 511 and max thr = 257, DONE is always reached.
- Outputs are registered; no combinational path from inputs to idump except through the pot_en=0 forcing term, which is also registered.
- Reset (async, any time, including mid-charge):
  - All channels go to DUMP with cnt=0 and thr=0.
  - hsync_d=1, idump=4'b0000, charging=4'b0000.
  - The first release after reset starts a fresh charge.
- Channels are fully independent. Simultaneous releases and ticks across channels need no arbitration.

Test Plan:
- Basic timing: pot_en=4'hF, pot0=10, dump 1->0, then hsync pulses every 64 clocks -> idump[0] rises exactly 1 clk after the 12th hsync rising edge after release; charging[0] high from release until then.
- Minimum/maximum: pot1=0 -> idump[1] high after the 2nd tick; pot2=255 -> idump[2] high after the 257th tick, with no wrap and cnt not exceeding 257.
- Dump priority: assert dump[3] on the same cycle as a line_tick mid-charge -> cnt3 clears, idump[3]=0 next edge; re-release restarts the count from 0.
- Pot latch: pot0=20 at release, change pot0 to 5 after 3 ticks -> completion still after the 22nd tick. The next dump cycle uses 5, completing after the 7th tick.
- Unconnected: pot_en=4'b0000, dump toggling -> idump equals ~dump (registered, 1-cycle delay) and charging stays 0. Clear pot_en[1] mid-charge -> channel 1 aborts to the forced-1 behaviour.
- Async reset mid-charge: reset pulse asserted between clock edges during CHARGE -> idump and charging go 0 immediately. After deassert with dump=0 held, no charge starts until dump toggles 1->0.

Source files
------------

// File: rtl/paddle_pot_timer.sv
// Four paddle pot/capacitor charge emulators feeding the TIA dumped inputs.
// Each channel counts scanlines after dump release and reports charge-complete.
module paddle_pot_timer #(
  parameter int unsigned MIN_LINES = 2,
  parameter int unsigned CNT_W     = 9
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [3:0] dump,
  input  logic       hsync,
  input  logic [7:0] pot0,
  input  logic [7:0] pot1,
  input  logic [7:0] pot2,
  input  logic [7:0] pot3,
  input  logic [3:0] pot_en,
  output logic [3:0] idump,
  output logic [3:0] charging
);

  localparam logic [1:0] ST_DUMP   = 2'd0;
  localparam logic [1:0] ST_CHARGE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic       hsync_d;
  logic       line_tick;
  logic [3:0] dump_d;
  logic [3:0] idump_nx;
  logic [3:0] charging_nx;
  logic [7:0] pot [4];

  always_comb begin
    pot[0] = pot0;
    pot[1] = pot1;
    pot[2] = pot2;
    pot[3] = pot3;
  end

  assign line_tick = hsync & ~hsync_d;

  // dump_d resets low so a release is only seen after a real 1->0 transition
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hsync_d  <= 1'b1;
      dump_d   <= '0;
      idump    <= '0;
      charging <= '0;
    end else begin
      hsync_d  <= hsync;
      dump_d   <= dump;
      idump    <= idump_nx;
      charging <= charging_nx;
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_ch
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] thr_nx;
    logic [CNT_W:0]   cnt_inc;

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      thr_nx   = thr;
      cnt_inc  = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
      if (!pot_en[n] || dump[n]) begin
        state_nx = ST_DUMP;
        cnt_nx   = '0;
      end else begin
        case (state)
          ST_DUMP: begin
            if (dump_d[n]) begin
              thr_nx   = CNT_W'(pot[n]) + CNT_W'(MIN_LINES);
              cnt_nx   = '0;
              state_nx = ST_CHARGE;
            end
          end
          ST_CHARGE: begin
            if (line_tick) begin
              cnt_nx = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
              if (cnt_inc >= {1'b0, thr}) state_nx = ST_DONE;
            end
          end
          ST_DONE: state_nx = ST_DONE;
          default: begin
            state_nx = ST_DUMP;
            cnt_nx   = '0;
          end
        endcase
      end
      // unconnected input floats high whenever the dump transistor is off
      idump_nx[n]    = (state_nx == ST_DONE) | (~pot_en[n] & ~dump[n]);
      charging_nx[n] = (state_nx == ST_CHARGE);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        state <= ST_DUMP;
        cnt   <= '0;
        thr   <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        thr   <= thr_nx;
      end
    end
  end

endmodule
